// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-256 encryption round controller.
package aes_pkg;

  localparam int AES_NR_256 = 14;
  localparam int AES_DW     = 128;

  typedef logic [127:0] aes_state_t;

  typedef enum logic [1:0] {
    ARK_ONLY = 2'd0,
    FULL     = 2'd1,
    LAST     = 2'd2
  } rnd_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ctrl_state_t;

  // Round 0 is the lone AddRoundKey, round nr drops MixColumns.
  function automatic rnd_mode_t mode_for_rnd(input logic [3:0] rnd, input logic [3:0] nr);
    if (rnd == 4'd0) return ARK_ONLY;
    else if (rnd >= nr) return LAST;
    else return FULL;
  endfunction

endpackage

// File: rtl/mod_enc_round_ctrl.sv
// Sequences one AES-256 block through the external round datapath, NR+1 stage passes.
// Latency: out_valid NR+2 cycles after the input handshake, plus one per key stall cycle.
// Backpressure: ciphertext held in DONE until out_ready; blk_count exists with ENC_CTRL_PERF_CNT_EN.
module mod_enc_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = AES_NR_256,
  parameter int DW = AES_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          key_valid,
  output logic [3:0]    rnd_key_idx,
  output logic [1:0]    rnd_mode,
  output logic [DW-1:0] rnd_data_o,
  input  logic [DW-1:0] rnd_data_i,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          busy
`ifdef ENC_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]   blk_count
`endif
);

  localparam logic [3:0] NR_L = 4'(NR);

  ctrl_state_t state_q;
  logic [3:0]  rnd_q;
  aes_state_t  st_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rnd_q   <= 4'd0;
      st_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            st_q    <= in_data;
            rnd_q   <= 4'd0;
            state_q <= RUN;
          end
        end
        RUN: begin
          // A counter beyond NR can only come from corruption; abandon the block.
          if (rnd_q > NR_L) begin
            rnd_q   <= 4'd0;
            state_q <= IDLE;
          end else if (key_valid) begin
            st_q <= rnd_data_i;
            if (rnd_q == NR_L) state_q <= DONE;
            else rnd_q <= rnd_q + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            rnd_q   <= 4'd0;
            state_q <= IDLE;
          end
        end
        default: begin
          rnd_q   <= 4'd0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    in_ready    = (state_q == IDLE);
    out_valid   = (state_q == DONE);
    busy        = (state_q != IDLE);
    rnd_key_idx = rnd_q;
    rnd_mode    = mode_for_rnd(rnd_q, NR_L);
    rnd_data_o  = st_q;
    out_data    = (state_q == DONE) ? st_q : '0;
  end

`ifdef ENC_CTRL_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blk_count <= 32'd0;
    else if ((state_q == DONE) && out_ready) blk_count <= blk_count + 32'd1;
  end
`endif

endmodule
